// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rx_state_t;

   localparam int unsigned OVERSAMPLE = 16;
   localparam int unsigned DATA_BITS  = 8;

endpackage

// File: rtl/rx_fifo.sv
// First-word-fall-through byte FIFO; a pop on a full FIFO frees the slot for a same-cycle push.
module rx_fifo import uart_pkg::*; #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = DATA_BITS
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    push,
   input  logic                    pop,
   input  logic [WIDTH-1:0]        wdata,
   output logic [WIDTH-1:0]        rdata,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    full,
   output logic                    empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wptr;
   logic [PTR_W-1:0] rptr;
   logic             do_push;
   logic             do_pop;

   // Status decode and accepted-operation qualification.
   always_comb begin
      empty   = (count == '0);
      full    = (count == CNT_W'(DEPTH));
      do_pop  = pop && !empty;
      do_push = push && (!full || do_pop);
      rdata   = empty ? '0 : mem[rptr];
   end

   // Storage array; the head is masked while empty so it never needs a reset.
   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= wdata;
   end

   // Pointers and occupancy.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) wptr <= wptr + PTR_W'(1);
         if (do_pop)  rptr <= rptr + PTR_W'(1);
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling feeding a small FWFT FIFO, sticky flags and level IRQ.
module uart_rx_fifo import uart_pkg::*; #(
   parameter int unsigned CLK_HZ = 50_000_000,
   parameter int unsigned BAUD   = 9600,
   parameter int unsigned DEPTH  = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    rx,
   input  logic                    rd,
   input  logic                    clr,
   output logic [DATA_BITS-1:0]    rx_data,
   output logic                    rx_valid,
   output logic [$clog2(DEPTH):0]  rx_count,
   output logic                    overrun,
   output logic                    frame_err,
   output logic                    irq
);

   localparam int unsigned DIV    = CLK_HZ / (BAUD * OVERSAMPLE);
   localparam int unsigned DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
   localparam int unsigned BIT_W  = $clog2(DATA_BITS);

   rx_state_t            state, state_next;
   logic                 sync1, rxs, rxs_prev;
   logic [DIV_W-1:0]     div_cnt;
   logic [TICK_W-1:0]    tick_cnt;
   logic [BIT_W-1:0]     bit_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 stop_wait;
   logic                 tick;
   logic                 tick_rst_c, shift_c, push_c, fe_set_c;
   logic                 fifo_full, fifo_empty;
   logic                 ovr_set;

   // Two-flop synchroniser plus one history flop for start-edge detection; idle level is 1.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1    <= 1'b1;
         rxs      <= 1'b1;
         rxs_prev <= 1'b1;
      end else begin
         sync1    <= rx;
         rxs      <= sync1;
         rxs_prev <= rxs;
      end
   end

   // Oversample tick: divider only runs while a frame is in progress.
   assign tick = (state != IDLE) && (div_cnt == DIV_W'(DIV - 1));

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   // Next-state and datapath strobes.
   always_comb begin
      state_next = state;
      tick_rst_c = 1'b0;
      shift_c    = 1'b0;
      push_c     = 1'b0;
      fe_set_c   = 1'b0;
      case (state)
         IDLE: begin
            if (rxs_prev && !rxs) state_next = START;
         end
         START: begin
            if (tick && tick_cnt == TICK_W'(OVERSAMPLE / 2 - 1)) begin
               if (rxs) begin
                  state_next = IDLE;
               end else begin
                  tick_rst_c = 1'b1;
                  state_next = DATA;
               end
            end
         end
         DATA: begin
            if (tick && tick_cnt == TICK_W'(OVERSAMPLE - 1)) begin
               shift_c = 1'b1;
               if (bit_cnt == BIT_W'(DATA_BITS - 1)) state_next = STOP;
            end
         end
         STOP: begin
            if (stop_wait) begin
               if (rxs) state_next = IDLE;
            end else if (tick && tick_cnt == TICK_W'(OVERSAMPLE - 1)) begin
               if (rxs) begin
                  push_c     = 1'b1;
                  state_next = IDLE;
               end else begin
                  fe_set_c   = 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Divider, tick/bit counters and shift register; all counters are held clear in IDLE.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_cnt   <= '0;
         tick_cnt  <= '0;
         bit_cnt   <= '0;
         shreg     <= '0;
         stop_wait <= 1'b0;
      end else begin
         if (state == IDLE) begin
            div_cnt  <= '0;
            tick_cnt <= '0;
            bit_cnt  <= '0;
         end else begin
            div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
            if (tick_rst_c) tick_cnt <= '0;
            else if (tick)  tick_cnt <= tick_cnt + TICK_W'(1);
            if (shift_c) begin
               shreg   <= {rxs, shreg[DATA_BITS-1:1]};
               bit_cnt <= bit_cnt + BIT_W'(1);
            end
         end
         // Bad stop bit: park in STOP until the line goes high again.
         if (state_next != STOP) stop_wait <= 1'b0;
         else if (fe_set_c)      stop_wait <= 1'b1;
      end
   end

   rx_fifo #(.DEPTH(DEPTH), .WIDTH(DATA_BITS)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_c),
      .pop   (rd),
      .wdata (shreg),
      .rdata (rx_data),
      .count (rx_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // A full FIFO is never empty, so any rd in the push cycle frees a slot.
   assign ovr_set = push_c && fifo_full && !rd;

   // Sticky flags; a set in the same cycle as clr wins.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         overrun   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         overrun   <= ovr_set  | (overrun   & ~clr);
         frame_err <= fe_set_c | (frame_err & ~clr);
      end
   end

   assign rx_valid = !fifo_empty;
   assign irq      = rx_valid;

endmodule
